// File: rtl/camera_ray_gen.sv
// Pinhole-camera ray source: raster-sweeps IMG_W x IMG_H pixels and issues one 8.24 ray per pixel
// round-robin to non-stalled ray_core instances. Optional abort input enabled by RAYGEN_ABORT_EN.
`timescale 1ns/1ps

module camera_ray_gen #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int NUM_CORES = 4,
  parameter int COORD_W   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [95:0]          cam_origin,
  input  logic [31:0]          step_x,
  input  logic [31:0]          step_y,
  input  logic [31:0]          focal,
  input  logic [NUM_CORES-1:0] stall_source,
`ifdef RAYGEN_ABORT_EN
  input  logic                 abort,
`endif
  output logic [COORD_W-1:0]   image_x,
  output logic [COORD_W-1:0]   image_y,
  output logic [95:0]          casted_ray_origin,
  output logic [95:0]          casted_ray_direction,
  output logic [NUM_CORES-1:0] new_data,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state;
  logic [RR_W-1:0]     rr;
  logic [NUM_CORES-1:0] holdoff;
  logic [COORD_W-1:0]  px, py;
  logic [31:0]         dir_x, dir_y, dir_x0;
  logic [95:0]         origin_q;
  logic [31:0]         step_x_q, step_y_q, focal_q;

  logic                abort_req;
`ifdef RAYGEN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Starting directions for pixel (0,0); modular arithmetic keeps the 8.24 two's complement wrap.
  logic [31:0] dir_x0_calc, dir_y0_calc;
  assign dir_x0_calc = 32'd0 - (step_x * 32'(IMG_W / 2));
  assign dir_y0_calc = step_y * 32'(IMG_H / 2);

  logic [NUM_CORES-1:0] eligible;
  logic                 found;
  logic [RR_W-1:0]      sel;
  logic [RR_W-1:0]      rr_next;
  logic [NUM_CORES-1:0] sel_onehot;

  assign eligible = ~stall_source & ~holdoff;

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    // Walk from the farthest candidate back to rr so the closest eligible core wins.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (eligible[idx]) begin
        found = 1'b1;
        sel   = RR_W'(idx);
      end
    end
    rr_next    = (int'(sel) == NUM_CORES - 1) ? '0 : sel + 1'b1;
    sel_onehot = NUM_CORES'(1) << sel;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      rr                   <= '0;
      holdoff              <= '0;
      px                   <= '0;
      py                   <= '0;
      dir_x                <= '0;
      dir_y                <= '0;
      dir_x0               <= '0;
      origin_q             <= '0;
      step_x_q             <= '0;
      step_y_q             <= '0;
      focal_q              <= '0;
      image_x              <= '0;
      image_y              <= '0;
      casted_ray_origin    <= '0;
      casted_ray_direction <= '0;
      new_data             <= '0;
      busy                 <= 1'b0;
      frame_done           <= 1'b0;
    end else begin
      new_data   <= '0;
      frame_done <= 1'b0;
      holdoff    <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            origin_q <= cam_origin;
            step_x_q <= step_x;
            step_y_q <= step_y;
            focal_q  <= focal;
            px       <= '0;
            py       <= '0;
            dir_x    <= dir_x0_calc;
            dir_x0   <= dir_x0_calc;
            dir_y    <= dir_y0_calc;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort_req) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (found) begin
            new_data             <= sel_onehot;
            holdoff              <= sel_onehot;
            rr                   <= rr_next;
            image_x              <= px;
            image_y              <= py;
            casted_ray_origin    <= origin_q;
            casted_ray_direction <= {focal_q, dir_y, dir_x};
            if (px == COORD_W'(IMG_W - 1)) begin
              px    <= '0;
              dir_x <= dir_x0;
              dir_y <= dir_y - step_y_q;
              if (py == COORD_W'(IMG_H - 1)) state <= DONE;
              else                           py    <= py + 1'b1;
            end else begin
              px    <= px + 1'b1;
              dir_x <= dir_x + step_x_q;
            end
          end
        end
        DONE: begin
          frame_done <= ~abort_req;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_ray_gen.sv
// Directed bench for camera_ray_gen: a single-core and a four-core instance on a 4x2 image.
`timescale 1ns/1ps

module tb_camera_ray_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic        abort = 1'b0;
  logic [95:0] cam_origin = '0;
  logic [31:0] step_x = '0, step_y = '0, focal = '0;
  logic [0:0]  stall1 = '0;
  logic [3:0]  stall4 = '0;

  logic [10:0] ix1, iy1, ix4, iy4;
  logic [95:0] org1, dir1, org4, dir4;
  logic [0:0]  nd1;
  logic [3:0]  nd4;
  logic        busy1, busy4, fd1, fd4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  camera_ray_gen #(.IMG_W(4), .IMG_H(2), .NUM_CORES(1), .COORD_W(11)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cam_origin(cam_origin),
    .step_x(step_x), .step_y(step_y), .focal(focal), .stall_source(stall1),
`ifdef RAYGEN_ABORT_EN
    .abort(abort),
`endif
    .image_x(ix1), .image_y(iy1), .casted_ray_origin(org1), .casted_ray_direction(dir1),
    .new_data(nd1), .busy(busy1), .frame_done(fd1)
  );

  camera_ray_gen #(.IMG_W(4), .IMG_H(2), .NUM_CORES(4), .COORD_W(11)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .cam_origin(cam_origin),
    .step_x(step_x), .step_y(step_y), .focal(focal), .stall_source(stall4),
`ifdef RAYGEN_ABORT_EN
    .abort(abort),
`endif
    .image_x(ix4), .image_y(iy4), .casted_ray_origin(org4), .casted_ray_direction(dir4),
    .new_data(nd4), .busy(busy4), .frame_done(fd4)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [31:0] dx;
    logic [31:0] dy;
  } vec_t;

  localparam logic [31:0] FOCAL  = 32'h0500_0000;
  localparam logic [95:0] ORIGIN = {32'hFB00_0000, 64'h0};

  vec_t tbl[8];
  logic [3:0] rr_pat[8];

  initial begin
    int idx, last, fd_cnt, seen;

    tbl[0] = '{11'd0, 11'd0, 32'hFF00_0000, 32'h0080_0000};
    tbl[1] = '{11'd1, 11'd0, 32'hFF80_0000, 32'h0080_0000};
    tbl[2] = '{11'd2, 11'd0, 32'h0000_0000, 32'h0080_0000};
    tbl[3] = '{11'd3, 11'd0, 32'h0080_0000, 32'h0080_0000};
    tbl[4] = '{11'd0, 11'd1, 32'hFF00_0000, 32'h0000_0000};
    tbl[5] = '{11'd1, 11'd1, 32'hFF80_0000, 32'h0000_0000};
    tbl[6] = '{11'd2, 11'd1, 32'h0000_0000, 32'h0000_0000};
    tbl[7] = '{11'd3, 11'd1, 32'h0080_0000, 32'h0000_0000};
    rr_pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset values.
    repeat (2) tick();
    check("reset nd4", 96'(nd4), 96'h0);
    check("reset busy4", 96'(busy4), 96'h0);
    check("reset dir4", dir4, 96'h0);
    check("reset org1", org1, 96'h0);
    check("reset ix1", 96'(ix1), 96'h0);
    rst = 1'b0;

    // Single core: strobes every other cycle, table-driven pixel and direction checks.
    cam_origin = ORIGIN;
    step_x = 32'h0080_0000;
    step_y = 32'h0080_0000;
    focal  = FOCAL;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("busy1 after start", 96'(busy1), 96'h1);
    idx = 0; last = 0; fd_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 3) cam_origin = 96'h0000_0001_0000_0002_0000_0003;
      if (nd1 == 1'b1) begin
        if (idx < 8) begin
          check($sformatf("n1 x[%0d]", idx), 96'(ix1), 96'(tbl[idx].x));
          check($sformatf("n1 y[%0d]", idx), 96'(iy1), 96'(tbl[idx].y));
          check($sformatf("n1 dir[%0d]", idx), dir1, {FOCAL, tbl[idx].dy, tbl[idx].dx});
          check($sformatf("n1 org[%0d]", idx), org1, ORIGIN);
        end else begin
          check("n1 extra strobe index", 96'(idx), 96'd7);
        end
        if (idx > 0) check("n1 strobe spacing", 96'(c - last), 96'd2);
        else         check("n1 first strobe cycle", 96'(c), 96'd1);
        last = c;
        idx++;
      end
      if (fd1) begin
        fd_cnt++;
        check("n1 frame_done lag", 96'(c - last), 96'd1);
      end
    end
    check("n1 strobe total", 96'(idx), 96'd8);
    check("n1 frame_done count", 96'(fd_cnt), 96'd1);
    check("n1 busy after frame", 96'(busy1), 96'h0);
    cam_origin = ORIGIN;

    // Four cores, no stall: round-robin on consecutive cycles.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("n4 rr[%0d]", c), 96'(nd4), 96'(rr_pat[c]));
      check($sformatf("n4 x[%0d]", c), 96'(ix4), 96'(tbl[c].x));
    end
    tick();
    check("n4 frame_done", 96'(fd4), 96'h1);
    check("n4 no strobe with done", 96'(nd4), 96'h0);
    tick();
    check("n4 frame_done one cycle", 96'(fd4), 96'h0);
    check("n4 busy after frame", 96'(busy4), 96'h0);

    // All cores stalled mid-frame: outputs hold, resume at the same pixel.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall pre rr[%0d]", c), 96'(nd4), 96'(rr_pat[c]));
    end
    stall4 = 4'hF;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall no strobe", 96'(nd4), 96'h0);
      check("stall x hold", 96'(ix4), 96'd2);
      check("stall y hold", 96'(iy4), 96'd0);
    end
    stall4 = 4'h0;
    tick();
    check("stall resume core", 96'(nd4), 96'b1000);
    check("stall resume x", 96'(ix4), 96'd3);
    check("stall resume dir", dir4, {FOCAL, tbl[3].dy, tbl[3].dx});
    idx = 0; seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (nd4 != 4'h0) idx++;
      if (fd4) seen = 1;
    end
    check("stall frame_done seen", 96'(seen), 96'd1);
    check("stall remaining strobes", 96'(idx), 96'd4);

    // Asynchronous reset during pixel 5.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (nd4 != 4'h0 && ix4 == 11'd1 && iy4 == 11'd1) seen = 1;
    end
    check("rst pixel5 seen", 96'(seen), 96'd1);
    #2 rst = 1'b1;
    #1;
    check("rst async nd4", 96'(nd4), 96'h0);
    check("rst async busy4", 96'(busy4), 96'h0);
    check("rst async ix4", 96'(ix4), 96'h0);
    check("rst async iy4", 96'(iy4), 96'h0);
    check("rst async dir4", dir4, 96'h0);
    check("rst async org4", org4, 96'h0);
    tick();
    rst = 1'b0;
    fd_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (fd4 || nd4 != 4'h0) fd_cnt++;
    end
    check("rst no activity after", 96'(fd_cnt), 96'd0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    check("rst restart core", 96'(nd4), 96'b0001);
    check("rst restart x", 96'(ix4), 96'd0);
    check("rst restart y", 96'(iy4), 96'd0);
    check("rst restart dir", dir4, {FOCAL, tbl[0].dy, tbl[0].dx});
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (fd4) seen = 1;
    end
    check("rst restart frame_done", 96'(seen), 96'd1);

`ifdef RAYGEN_ABORT_EN
    // Abort at pixel 3: nothing further, busy drops, no frame_done.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (nd4 != 4'h0 && ix4 == 11'd3 && iy4 == 11'd0) seen = 1;
    end
    check("abort pixel3 seen", 96'(seen), 96'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort no strobe", 96'(nd4), 96'h0);
    check("abort busy drop", 96'(busy4), 96'h0);
    fd_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (fd4 || nd4 != 4'h0) fd_cnt++;
    end
    check("abort quiet after", 96'(fd_cnt), 96'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
